// File: rtl/command_queue_if.sv
// -----------------------------------------------------------------------------
// command_queue_if
//   Bundles the fetch-side, decode-side and status signals of command_queue.
//
//   Handshake semantics (single comment, applies to the whole bundle):
//     - comm_write is a one-cycle strobe. When it is high, rom_data carries one
//       ROM word, and the queue always samples it. Back-pressure is advisory:
//       the fetch stage must stall while pause_READ is high. A word that
//       completes a pair while the queue is full is dropped and flagged.
//     - comm_read is a one-cycle strobe. When it is high, the head shown on
//       command_in is consumed. Decode must stall while pause_DECODE is high.
//       A read while empty is ignored and flagged.
//     - flush overrides both strobes in the cycle in which it is high.
//
//   Modports:
//     master : the stimulus/neighbour side (drives strobes and data)
//     slave  : the queue itself (drives head command and status)
// -----------------------------------------------------------------------------
interface command_queue_if #(
   parameter int DATA_W = 14,
   parameter int PTR_W  = 3
);
   logic                  comm_write;
   logic [DATA_W-1:0]     rom_data;
   logic                  comm_read;
   logic                  flush;
   logic [2*DATA_W-1:0]   command_in;
   logic                  pause_READ;
   logic                  pause_DECODE;
   logic                  half_pending;
   logic [PTR_W:0]        count;
   logic                  overflow;
   logic                  underflow;

   modport master (
      output comm_write, rom_data, comm_read, flush,
      input  command_in, pause_READ, pause_DECODE, half_pending,
             count, overflow, underflow
   );

   modport slave (
      input  comm_write, rom_data, comm_read, flush,
      output command_in, pause_READ, pause_DECODE, half_pending,
             count, overflow, underflow
   );
endinterface

// File: rtl/command_queue.sv
// -----------------------------------------------------------------------------
// command_queue
//   Instruction buffer between ROM fetch and decode. Pairs of DATA_W-bit ROM
//   words are packed into 2*DATA_W-bit commands (first word in the upper half)
//   and queued in a DEPTH-entry FIFO. The head is shown ahead on command_in.
//
//   Ports:
//     clk    - system clock, all state changes on the rising edge
//     reset  - synchronous, active-high reset
//     bus    - command_queue_if.slave:
//                comm_write/rom_data : ROM word strobe and data
//                comm_read           : decode pops the head command
//                flush               : drop all queued and half-built commands
//                command_in          : head command, zero while empty
//                pause_READ          : queue full, fetch stalls
//                pause_DECODE        : queue empty, decode stalls
//                half_pending        : first word of a pair is being held
//                count               : number of complete commands (0..DEPTH)
//                overflow/underflow  : sticky error flags, cleared by reset only
// -----------------------------------------------------------------------------
module command_queue #(
   parameter int DATA_W = 14,
   parameter int DEPTH  = 8,
   parameter int PTR_W  = 3
) (
   input logic               clk,
   input logic               reset,
   command_queue_if.slave    bus
);

   localparam int            CMD_W    = 2 * DATA_W;
   localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

   // ---------------------------------------------------------------------------
   // State
   // ---------------------------------------------------------------------------
   logic [CMD_W-1:0]  mem [DEPTH];
   logic [PTR_W-1:0]  wr_ptr;
   logic [PTR_W-1:0]  rd_ptr;
   logic [PTR_W:0]    count_q;
   logic              half_q;
   logic [DATA_W-1:0] hold_q;
   logic              overflow_q;
   logic              underflow_q;

   // ---------------------------------------------------------------------------
   // Decoded conditions (all from registered state, no extra latency)
   // ---------------------------------------------------------------------------
   logic is_full;
   logic is_empty;
   logic pair_done;
   logic do_pop;
   logic do_push;
   logic do_drop;
   logic bad_read;

   assign is_full   = (count_q == FULL_CNT);
   assign is_empty  = (count_q == '0);

   // The second word of a pair completes a command.
   assign pair_done = bus.comm_write && half_q;

   // A pop needs an entry present before the edge; a push in the same cycle
   // never falls through to satisfy a read on an empty queue.
   assign do_pop    = bus.comm_read && !is_empty;

   // At full, a completing write is only accepted if a pop frees a slot in
   // the same cycle; otherwise the finished command is discarded.
   assign do_push   = pair_done && (!is_full || do_pop);
   assign do_drop   = pair_done && is_full && !do_pop;
   assign bad_read  = bus.comm_read && is_empty;

   // ---------------------------------------------------------------------------
   // Pair assembly: hold register doubles as a one-word skid when full.
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (reset) begin
         half_q <= 1'b0;
         hold_q <= '0;
      end else if (bus.flush) begin
         half_q <= 1'b0;
      end else if (bus.comm_write) begin
         if (!half_q) begin
            hold_q <= bus.rom_data;
            half_q <= 1'b1;
         end else begin
            half_q <= 1'b0;
         end
      end
   end

   // ---------------------------------------------------------------------------
   // Storage. Memory is not reset; stale contents are never shown because
   // command_in is forced to zero while the queue is empty.
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (!reset && !bus.flush && do_push) begin
         mem[wr_ptr] <= {hold_q, bus.rom_data};
      end
   end

   // ---------------------------------------------------------------------------
   // Pointers and occupancy. Pointers wrap naturally at PTR_W bits.
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (reset || bus.flush) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         count_q <= '0;
      end else begin
         if (do_push) begin
            wr_ptr <= wr_ptr + PTR_W'(1);
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + PTR_W'(1);
         end
         case ({do_push, do_pop})
            2'b10:   count_q <= count_q + (PTR_W + 1)'(1);
            2'b01:   count_q <= count_q - (PTR_W + 1)'(1);
            default: count_q <= count_q;
         endcase
      end
   end

   // ---------------------------------------------------------------------------
   // Sticky error flags: survive flush, cleared by reset only. Nothing is
   // flagged in a flush cycle because the strobes are ignored there.
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (reset) begin
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
      end else if (!bus.flush) begin
         if (do_drop) begin
            overflow_q <= 1'b1;
         end
         if (bad_read) begin
            underflow_q <= 1'b1;
         end
      end
   end

   // ---------------------------------------------------------------------------
   // Outputs
   // ---------------------------------------------------------------------------
   assign bus.command_in   = is_empty ? '0 : mem[rd_ptr];
   assign bus.pause_READ   = is_full;
   assign bus.pause_DECODE = is_empty;
   assign bus.half_pending = half_q;
   assign bus.count        = count_q;
   assign bus.overflow     = overflow_q;
   assign bus.underflow    = underflow_q;

endmodule

// File: tb/tb_command_queue.sv
// -----------------------------------------------------------------------------
// tb_command_queue
//   Directed bench for command_queue. A driver applies one cycle of strobes
//   at a time; a negedge monitor keeps the expected command queue and flag
//   model, compares every cycle, and retires/appends expected commands.
//   Directed checks after key steps use hand-computed constants.
// -----------------------------------------------------------------------------
module tb_command_queue;

   localparam int DATA_W = 14;
   localparam int DEPTH  = 8;
   localparam int PTR_W  = 3;
   localparam int CMD_W  = 2 * DATA_W;

   // ---------------------------------------------------------------------------
   // Clock / reset
   // ---------------------------------------------------------------------------
   logic clk   = 1'b0;
   logic reset = 1'b1;

   always #5 clk = ~clk;

   command_queue_if #(.DATA_W(DATA_W), .PTR_W(PTR_W)) bus ();

   command_queue #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH),
      .PTR_W  (PTR_W)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   // ---------------------------------------------------------------------------
   // Scoreboard state
   // ---------------------------------------------------------------------------
   logic [CMD_W-1:0]  exp_q[$];
   logic              m_half = 1'b0;
   logic [DATA_W-1:0] m_hold = '0;
   logic              m_ovf  = 1'b0;
   logic              m_unf  = 1'b0;
   int                n_checks = 0;
   int                n_errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------------------------------------------------------------------
   // Monitor: compare visible state against the model, then apply this
   // cycle's strobes to the model (they take effect at the next posedge).
   // ---------------------------------------------------------------------------
   always @(negedge clk) begin
      int   sz;
      logic popped;
      if (reset) begin
         exp_q.delete();
         m_half = 1'b0;
         m_ovf  = 1'b0;
         m_unf  = 1'b0;
      end else begin
         sz = exp_q.size();
         chk("mon_count",        32'(bus.count),        32'(sz));
         chk("mon_pause_DECODE", 32'(bus.pause_DECODE), 32'(sz == 0));
         chk("mon_pause_READ",   32'(bus.pause_READ),   32'(sz == DEPTH));
         chk("mon_half_pending", 32'(bus.half_pending), 32'(m_half));
         chk("mon_overflow",     32'(bus.overflow),     32'(m_ovf));
         chk("mon_underflow",    32'(bus.underflow),    32'(m_unf));
         chk("mon_command_in",   32'(bus.command_in),   (sz > 0) ? 32'(exp_q[0]) : 32'd0);

         popped = 1'b0;
         if (bus.flush) begin
            exp_q.delete();
            m_half = 1'b0;
         end else begin
            if (bus.comm_read) begin
               if (sz > 0) begin
                  void'(exp_q.pop_front());
                  popped = 1'b1;
               end else begin
                  m_unf = 1'b1;
               end
            end
            if (bus.comm_write) begin
               if (!m_half) begin
                  m_hold = bus.rom_data;
                  m_half = 1'b1;
               end else begin
                  m_half = 1'b0;
                  if (sz < DEPTH || popped) exp_q.push_back({m_hold, bus.rom_data});
                  else                      m_ovf = 1'b1;
               end
            end
         end
      end
   end

   // ---------------------------------------------------------------------------
   // Driver tasks
   // ---------------------------------------------------------------------------
   task automatic step(input logic cw, input logic [DATA_W-1:0] d,
                       input logic cr, input logic fl);
      bus.comm_write = cw;
      bus.rom_data   = d;
      bus.comm_read  = cr;
      bus.flush      = fl;
      @(posedge clk);
      #1;
      bus.comm_write = 1'b0;
      bus.rom_data   = '0;
      bus.comm_read  = 1'b0;
      bus.flush      = 1'b0;
   endtask

   task automatic push_pair(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b);
      step(1'b1, a, 1'b0, 1'b0);
      step(1'b1, b, 1'b0, 1'b0);
   endtask

   task automatic pop_one();
      step(1'b0, '0, 1'b1, 1'b0);
   endtask

   // Watchdog
   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not end, time %0t", $time);
      $fatal(1, "watchdog expired");
   end

   // ---------------------------------------------------------------------------
   // Directed stimulus
   // ---------------------------------------------------------------------------
   initial begin
      bus.comm_write = 1'b0;
      bus.rom_data   = '0;
      bus.comm_read  = 1'b0;
      bus.flush      = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;

      // Reset state
      chk("rst_command_in",   32'(bus.command_in),   32'd0);
      chk("rst_pause_DECODE", 32'(bus.pause_DECODE), 32'd1);
      chk("rst_pause_READ",   32'(bus.pause_READ),   32'd0);
      chk("rst_count",        32'(bus.count),        32'd0);

      // Basic pair
      push_pair(14'h0A5, 14'h3C1);
      chk("pair_command_in",   32'(bus.command_in),   32'h02943C1);
      chk("pair_count",        32'(bus.count),        32'd1);
      chk("pair_pause_DECODE", 32'(bus.pause_DECODE), 32'd0);
      chk("pair_half",         32'(bus.half_pending), 32'd0);
      pop_one();
      chk("pair_popped_count", 32'(bus.count), 32'd0);

      // Fill with 1..16
      for (int i = 1; i <= 8; i++) push_pair(DATA_W'(2*i-1), DATA_W'(2*i));
      chk("fill_count",      32'(bus.count),      32'd8);
      chk("fill_pause_READ", 32'(bus.pause_READ), 32'd1);
      chk("fill_head",       32'(bus.command_in), 32'h0004002);

      // Pop 3, push 3 more across the pointer wrap
      repeat (3) pop_one();
      for (int i = 9; i <= 11; i++) push_pair(DATA_W'(2*i-1), DATA_W'(2*i));
      chk("wrap_count", 32'(bus.count),      32'd8);
      chk("wrap_head",  32'(bus.command_in), 32'h001C008);

      // Skid then overflow
      step(1'b1, 14'h100, 1'b0, 1'b0);
      chk("skid_half", 32'(bus.half_pending), 32'd1);
      chk("skid_ovf",  32'(bus.overflow),     32'd0);
      step(1'b1, 14'h101, 1'b0, 1'b0);
      chk("drop_count", 32'(bus.count),        32'd8);
      chk("drop_ovf",   32'(bus.overflow),     32'd1);
      chk("drop_half",  32'(bus.half_pending), 32'd0);

      // Completing write with simultaneous pop at full
      step(1'b1, 14'h200, 1'b0, 1'b0);
      step(1'b1, 14'h201, 1'b1, 1'b0);
      chk("fullpp_count", 32'(bus.count),    32'd8);
      chk("fullpp_ovf",   32'(bus.overflow), 32'd1);

      // Drain in push order (order checked by the monitor)
      repeat (7) pop_one();
      chk("drain_last_head", 32'(bus.command_in), 32'h0800201);
      pop_one();
      chk("drain_count", 32'(bus.count), 32'd0);

      // Underflow
      pop_one();
      chk("unf_flag",       32'(bus.underflow),  32'd1);
      chk("unf_count",      32'(bus.count),      32'd0);
      chk("unf_command_in", 32'(bus.command_in), 32'd0);

      // Pair completes in the same cycle as a read on an empty queue
      step(1'b1, 14'h011, 1'b0, 1'b0);
      step(1'b1, 14'h022, 1'b1, 1'b0);
      chk("nofall_count", 32'(bus.count),      32'd1);
      chk("nofall_head",  32'(bus.command_in), 32'h0044022);

      // Flush with count=5 and a half-built pair
      for (int i = 0; i < 4; i++) push_pair(DATA_W'(16'h30 + i), DATA_W'(16'h40 + i));
      step(1'b1, 14'h055, 1'b0, 1'b0);
      chk("preflush_count", 32'(bus.count),        32'd5);
      chk("preflush_half",  32'(bus.half_pending), 32'd1);
      step(1'b1, 14'h3FF, 1'b1, 1'b1);
      chk("flush_count",        32'(bus.count),        32'd0);
      chk("flush_half",         32'(bus.half_pending), 32'd0);
      chk("flush_pause_DECODE", 32'(bus.pause_DECODE), 32'd1);
      chk("flush_pause_READ",   32'(bus.pause_READ),   32'd0);
      chk("flush_ovf_kept",     32'(bus.overflow),     32'd1);
      chk("flush_unf_kept",     32'(bus.underflow),    32'd1);

      // Reset mid-operation
      for (int i = 0; i < 4; i++) push_pair(DATA_W'(16'h60 + i), DATA_W'(16'h70 + i));
      step(1'b1, 14'h077, 1'b0, 1'b0);
      chk("prerst_count", 32'(bus.count), 32'd4);
      reset = 1'b1;
      @(posedge clk);
      #1;
      reset = 1'b0;
      chk("rst2_count",        32'(bus.count),        32'd0);
      chk("rst2_half",         32'(bus.half_pending), 32'd0);
      chk("rst2_ovf",          32'(bus.overflow),     32'd0);
      chk("rst2_unf",          32'(bus.underflow),    32'd0);
      chk("rst2_command_in",   32'(bus.command_in),   32'd0);
      chk("rst2_pause_DECODE", 32'(bus.pause_DECODE), 32'd1);
      chk("rst2_pause_READ",   32'(bus.pause_READ),   32'd0);

      // Held word was discarded: a fresh pair packs cleanly
      push_pair(14'h001, 14'h002);
      chk("post_rst_head", 32'(bus.command_in), 32'h0004002);
      repeat (2) @(posedge clk);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/command_queue.md
Name: command_queue

Overview:
- Instruction buffer between the ROM-fetch stage and the decode stage of the pipelined CPU control.
- Packs pairs of DATA_W-bit ROM words, strobed by comm_write, into 2*DATA_W-bit commands and queues them in a DEPTH-entry FIFO.
- Presents the head command show-ahead on command_in; decode pops it with comm_read.
- Generates pause_READ (queue full) and pause_DECODE (queue empty) to throttle the neighbouring stages.

Parameters:
- DATA_W, 14, width of one ROM word; a command is 2*DATA_W.
- DEPTH, 8, number of command entries; must be a power of two, at least 2.
- PTR_W, 3, log2(DEPTH); width of the read and write pointers.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- reset  input  1  synchronous, active-high reset.
- comm_write  input  1  one valid ROM word on rom_data this cycle.
- rom_data  input  DATA_W  ROM word from the fetch stage.
- comm_read  input  1  decode consumes the head command this cycle.
- flush  input  1  discard all queued and half-assembled commands (control-flow change).
- command_in  output  2*DATA_W  head command, show-ahead; zero when empty.
- pause_READ  output  1  queue full; fetch must stall.
- pause_DECODE  output  1  queue empty; decode must stall.
- half_pending  output  1  first word of a pair is held, awaiting the second.
- count  output  PTR_W+1  number of complete commands queued (0..DEPTH).
- overflow  output  1  sticky: a completed command was dropped.
- underflow  output  1  sticky: comm_read was received while empty.

Behaviour:
- Reset, applied synchronously on a clk edge while reset=1:
  - wr_ptr, rd_ptr, count, half_pending, hold register, overflow and underflow all go to 0.
  - Outputs after reset: command_in=0, pause_READ=0, pause_DECODE=1.
  - Reset mid-assembly discards the held word.
- Word packing:
  - First comm_write of a pair: hold <= rom_data; half_pending <= 1.
  - Second comm_write: the entry {hold, rom_data} is pushed, with hold in bits [2*DATA_W-1:DATA_W] and rom_data in [DATA_W-1:0]; half_pending <= 0.
  - Pair state is independent of pops.
- Push:
  - Occurs only on the second word of a pair.
  - Writes mem[wr_ptr]; wr_ptr increments modulo DEPTH, with natural PTR_W wrap.
  - The new entry is visible on command_in the cycle after the edge that pushed it, if the queue was empty.
- Pop:
  - comm_read with count>0 increments rd_ptr modulo DEPTH.
  - The next entry appears on command_in the following cycle.
  - comm_read with count=0 is ignored and sets underflow. There is no fall-through, even if a push occurs that same cycle.
- Simultaneous push and pop with 0<count<=DEPTH:
  - Both are performed and count is unchanged.
  - At count=DEPTH this is legal and does not set overflow.
- Full condition:
  - pause_READ = (count==DEPTH), decoded from registered state with no extra cycle of delay.
  - comm_write while full and half_pending=0 is accepted into hold, which acts as a one-word skid.
  - A completing write while full and without a simultaneous pop drops the command: no memory or pointer change, half_pending <= 0, overflow <= 1.
- Empty condition: pause_DECODE = (count==0); command_in is forced to 0 while empty.
- count arithmetic:
  - count is PTR_W+1 bits: +1 on push only, -1 on pop only.
  - Never wraps, because overflow and underflow cases are blocked as defined above.
- Flush, highest priority after reset:
  - In the flush cycle, comm_write and comm_read are ignored.
  - Pointers, count and half_pending are cleared; memory contents are don't-care.
  - Sticky flags are not cleared by flush; only reset clears them.
- Priority order: reset > flush > push/pop.

Test Plan:
- Basic pair: after reset, comm_write with rom_data=14'h0A5, then 14'h3C1 on consecutive cycles -> next cycle command_in=28'h02943C1 (=(14'h0A5<<14)|14'h3C1), count=1, pause_DECODE=0, half_pending=0.
- Fill and wrap:
  - Push 8 pairs with values 1..16 -> count=8, pause_READ=1.
  - Pop 3 and push 3 more -> command_in order preserved across the pointer wrap.
  - Final pops return the pairs in push order.
- Full skid/overflow:
  - At count=8, one comm_write -> half_pending=1, overflow=0.
  - A second write without a pop -> count stays 8, overflow=1, half_pending=0.
  - Repeating the second write with comm_read high -> accepted, count=8, overflow unchanged.
- Underflow:
  - comm_read at count=0 -> underflow=1, count=0, command_in=0.
  - Completing a pair in the same cycle as a comm_read at count=0 -> count=1 next cycle.
- Flush:
  - With count=5 and half_pending=1, assert flush together with comm_write and comm_read -> next cycle count=0, half_pending=0, pause_DECODE=1, pause_READ=0.
  - Sticky flags are retained.
- Reset mid-operation: reset asserted with count=4, overflow=1 and half_pending=1 -> all outputs return to their reset values on the next edge.
